// File: rtl/branch_history_unit_if.sv
// Port bundle between the gshare history front end and its fetch/execute/PHT neighbours.
// The master side is the pipeline + PHT; the slave side is branch_history_unit.
interface branch_history_unit_if #(
    parameter int unsigned REGSIZE = 2
);
    logic [31:0]        fetch_pc;
    logic               fetch_is_branch;
    logic [1:0]         pred_count;
    logic               res_valid;
    logic               res_taken;
    logic [REGSIZE-1:0] pattern_addr;
    logic               en;
    logic               pcbranch;
    logic               pred_taken;
    logic               mispredict;
    logic               stall;
    logic               protocol_err;

    modport master (
        output fetch_pc, fetch_is_branch, pred_count, res_valid, res_taken,
        input  pattern_addr, en, pcbranch, pred_taken, mispredict, stall, protocol_err
    );

    modport slave (
        input  fetch_pc, fetch_is_branch, pred_count, res_valid, res_taken,
        output pattern_addr, en, pcbranch, pred_taken, mispredict, stall, protocol_err
    );
endinterface

// File: rtl/branch_history_unit.sv
// Speculative/architectural global history with an in-flight branch queue; forms gshare
// PHT indices, replays the lookup index at update time and repairs history on mispredict.
module branch_history_unit #(
    parameter int unsigned REGSIZE = 2,
    parameter int unsigned DEPTH   = 2
) (
    input logic                   clk,
    input logic                   rstn,
    branch_history_unit_if.slave  bus
);
    // DEPTH is a power of two >= 2 so the pointers wrap naturally.
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [REGSIZE-1:0] spec_ghr_q, spec_ghr_d;
    logic [REGSIZE-1:0] arch_ghr_q, arch_ghr_d;
    logic [REGSIZE-1:0] q_idx_q  [DEPTH];
    logic [REGSIZE-1:0] q_idx_d  [DEPTH];
    logic [DEPTH-1:0]   q_pred_q, q_pred_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               perr_q, perr_d;

    logic [REGSIZE-1:0] lookup_idx;
    logic [REGSIZE-1:0] head_idx;
    logic               head_pred;
    logic               full, empty, push, pop, mispredict;

    always_comb begin
        lookup_idx = spec_ghr_q ^ bus.fetch_pc[REGSIZE+1:2];
        head_idx   = q_idx_q[rd_ptr_q];
        head_pred  = q_pred_q[rd_ptr_q];
        full       = (cnt_q == DepthCnt);
        empty      = (cnt_q == '0);
        // The PHT port belongs to the update while res_valid is high, so no lookup/push then.
        push       = bus.fetch_is_branch & ~bus.res_valid & ~full;
        pop        = bus.res_valid & ~empty;
        mispredict = pop & (bus.res_taken ^ head_pred);
    end

    always_comb begin
        bus.pattern_addr = pop ? head_idx : lookup_idx;
        bus.en           = pop;
        bus.pcbranch     = pop & bus.res_taken;
        bus.pred_taken   = push & bus.pred_count[1];
        bus.mispredict   = mispredict;
        bus.stall        = bus.fetch_is_branch & (full | bus.res_valid);
        bus.protocol_err = perr_q;
    end

    always_comb begin
        spec_ghr_d = spec_ghr_q;
        arch_ghr_d = arch_ghr_q;
        q_idx_d    = q_idx_q;
        q_pred_d   = q_pred_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        perr_d     = perr_q;

        if (push) begin
            q_idx_d[wr_ptr_q]  = lookup_idx;
            q_pred_d[wr_ptr_q] = bus.pred_count[1];
            wr_ptr_d           = wr_ptr_q + 1'b1;
            cnt_d              = cnt_q + 1'b1;
            spec_ghr_d         = {spec_ghr_q[REGSIZE-2:0], bus.pred_count[1]};
        end

        if (pop) begin
            arch_ghr_d = {arch_ghr_q[REGSIZE-2:0], bus.res_taken};
            if (mispredict) begin
                // Younger entries are flushed by the pipeline; rebuild from committed history.
                spec_ghr_d = {arch_ghr_q[REGSIZE-2:0], bus.res_taken};
                rd_ptr_d   = '0;
                wr_ptr_d   = '0;
                cnt_d      = '0;
            end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                cnt_d    = cnt_q - 1'b1;
            end
        end

        if (bus.res_valid && empty) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spec_ghr_q <= '0;
            arch_ghr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_idx_q[i] <= '0;
            end
            q_pred_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            perr_q     <= 1'b0;
        end else begin
            spec_ghr_q <= spec_ghr_d;
            arch_ghr_q <= arch_ghr_d;
            q_idx_q    <= q_idx_d;
            q_pred_q   <= q_pred_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            perr_q     <= perr_d;
        end
    end
endmodule

// File: tb/tb_branch_history_unit.sv
// Directed bench for branch_history_unit (REGSIZE=2, DEPTH=2); spec_ghr is observed as
// pattern_addr with fetch_pc=0 and no resolve, queue occupancy via stall/en/protocol_err.
module tb_branch_history_unit;
    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;

    branch_history_unit_if #(.REGSIZE(2)) bus ();

    branch_history_unit #(.REGSIZE(2), .DEPTH(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] pc, input logic br, input logic [1:0] cnt,
                         input logic rv, input logic rt);
        bus.fetch_pc        = pc;
        bus.fetch_is_branch = br;
        bus.pred_count      = cnt;
        bus.res_valid       = rv;
        bus.res_taken       = rt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(32'h8, 1'b1, 2'b11, 1'b1, 1'b1);
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %b want 1", bus.stall); end
        n_cmp++; if (bus.pattern_addr !== 2'b10) begin n_err++; $display("FAIL rst_addr: got %b want 10", bus.pattern_addr); end
        n_cmp++; if (bus.en !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b want 0", bus.en); end
        n_cmp++; if (bus.pcbranch !== 1'b0) begin n_err++; $display("FAIL rst_pcbranch: got %b want 0", bus.pcbranch); end
        n_cmp++; if (bus.mispredict !== 1'b0) begin n_err++; $display("FAIL rst_mispredict: got %b want 0", bus.mispredict); end
        n_cmp++; if (bus.protocol_err !== 1'b0) begin n_err++; $display("FAIL rst_perr: got %b want 0", bus.protocol_err); end
        drive(32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_push();
        drive(32'h8, 1'b1, 2'b11, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b10) begin n_err++; $display("FAIL push1_addr: got %b want 10", bus.pattern_addr); end
        n_cmp++; if (bus.pred_taken !== 1'b1) begin n_err++; $display("FAIL push1_pred: got %b want 1", bus.pred_taken); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL push1_stall: got %b want 0", bus.stall); end
        tick();
        drive(32'h0, 1'b0, 2'b11, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b01) begin n_err++; $display("FAIL spec_after_push1: got %b want 01", bus.pattern_addr); end
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL no_push_pred: got %b want 0", bus.pred_taken); end
        drive(32'h4, 1'b1, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b00) begin n_err++; $display("FAIL push2_addr: got %b want 00", bus.pattern_addr); end
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL push2_pred: got %b want 0", bus.pred_taken); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL push2_stall: got %b want 0", bus.stall); end
        tick();
        drive(32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b10) begin n_err++; $display("FAIL spec_after_push2: got %b want 10", bus.pattern_addr); end
    endtask

    task automatic test_full();
        drive(32'hC, 1'b1, 2'b11, 1'b0, 1'b0);
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL full_stall: got %b want 1", bus.stall); end
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL full_pred: got %b want 0", bus.pred_taken); end
        n_cmp++; if (bus.en !== 1'b0) begin n_err++; $display("FAIL full_en: got %b want 0", bus.en); end
        tick();
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL full_stall_hold: got %b want 1", bus.stall); end
        drive(32'h0, 1'b0, 2'b11, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b10) begin n_err++; $display("FAIL full_spec_hold: got %b want 10", bus.pattern_addr); end
    endtask

    task automatic test_resolve();
        drive(32'h0, 1'b0, 2'b00, 1'b1, 1'b1);
        n_cmp++; if (bus.en !== 1'b1) begin n_err++; $display("FAIL res1_en: got %b want 1", bus.en); end
        n_cmp++; if (bus.pcbranch !== 1'b1) begin n_err++; $display("FAIL res1_pcbranch: got %b want 1", bus.pcbranch); end
        n_cmp++; if (bus.pattern_addr !== 2'b10) begin n_err++; $display("FAIL res1_addr: got %b want 10", bus.pattern_addr); end
        n_cmp++; if (bus.mispredict !== 1'b0) begin n_err++; $display("FAIL res1_mispredict: got %b want 0", bus.mispredict); end
        tick();
        // Branch presented alongside a resolve on a non-full queue: stalled, head index shown.
        drive(32'h8, 1'b1, 2'b11, 1'b1, 1'b1);
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL res_stall: got %b want 1", bus.stall); end
        n_cmp++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL res_pred: got %b want 0", bus.pred_taken); end
        n_cmp++; if (bus.pattern_addr !== 2'b00) begin n_err++; $display("FAIL res2_addr: got %b want 00", bus.pattern_addr); end
        n_cmp++; if (bus.mispredict !== 1'b1) begin n_err++; $display("FAIL res2_mispredict: got %b want 1", bus.mispredict); end
        n_cmp++; if (bus.en !== 1'b1) begin n_err++; $display("FAIL res2_en: got %b want 1", bus.en); end
        tick();
        drive(32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b11) begin n_err++; $display("FAIL spec_restored: got %b want 11", bus.pattern_addr); end
    endtask

    task automatic test_protocol_err();
        drive(32'h4, 1'b0, 2'b00, 1'b1, 1'b1);
        n_cmp++; if (bus.en !== 1'b0) begin n_err++; $display("FAIL empty_en: got %b want 0", bus.en); end
        n_cmp++; if (bus.mispredict !== 1'b0) begin n_err++; $display("FAIL empty_mispredict: got %b want 0", bus.mispredict); end
        n_cmp++; if (bus.pattern_addr !== 2'b10) begin n_err++; $display("FAIL empty_addr: got %b want 10", bus.pattern_addr); end
        n_cmp++; if (bus.protocol_err !== 1'b0) begin n_err++; $display("FAIL perr_early: got %b want 0", bus.protocol_err); end
        tick();
        drive(32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (bus.protocol_err !== 1'b1) begin n_err++; $display("FAIL perr_set: got %b want 1", bus.protocol_err); end
        tick();
        tick();
        n_cmp++; if (bus.protocol_err !== 1'b1) begin n_err++; $display("FAIL perr_hold: got %b want 1", bus.protocol_err); end
        n_cmp++; if (bus.pattern_addr !== 2'b11) begin n_err++; $display("FAIL perr_spec_hold: got %b want 11", bus.pattern_addr); end
    endtask

    task automatic test_back_to_back();
        drive(32'h0, 1'b1, 2'b11, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b11) begin n_err++; $display("FAIL b2b_a_addr: got %b want 11", bus.pattern_addr); end
        tick();
        drive(32'h4, 1'b1, 2'b10, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b10) begin n_err++; $display("FAIL b2b_b_addr: got %b want 10", bus.pattern_addr); end
        n_cmp++; if (bus.pred_taken !== 1'b1) begin n_err++; $display("FAIL b2b_b_pred: got %b want 1", bus.pred_taken); end
        tick();
        drive(32'h0, 1'b0, 2'b00, 1'b1, 1'b1);
        n_cmp++; if (bus.pattern_addr !== 2'b11) begin n_err++; $display("FAIL b2b_res_a_addr: got %b want 11", bus.pattern_addr); end
        n_cmp++; if (bus.mispredict !== 1'b0) begin n_err++; $display("FAIL b2b_res_a_mp: got %b want 0", bus.mispredict); end
        tick();
        // Write pointer wraps to slot 0 here.
        drive(32'h8, 1'b1, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b01) begin n_err++; $display("FAIL b2b_c_addr: got %b want 01", bus.pattern_addr); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL b2b_c_stall: got %b want 0", bus.stall); end
        tick();
        drive(32'h0, 1'b0, 2'b00, 1'b1, 1'b1);
        n_cmp++; if (bus.pattern_addr !== 2'b10) begin n_err++; $display("FAIL b2b_res_b_addr: got %b want 10", bus.pattern_addr); end
        n_cmp++; if (bus.mispredict !== 1'b0) begin n_err++; $display("FAIL b2b_res_b_mp: got %b want 0", bus.mispredict); end
        tick();
        drive(32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b01) begin n_err++; $display("FAIL b2b_res_c_addr: got %b want 01", bus.pattern_addr); end
        n_cmp++; if (bus.mispredict !== 1'b0) begin n_err++; $display("FAIL b2b_res_c_mp: got %b want 0", bus.mispredict); end
        n_cmp++; if (bus.pcbranch !== 1'b0) begin n_err++; $display("FAIL b2b_res_c_pcb: got %b want 0", bus.pcbranch); end
        n_cmp++; if (bus.en !== 1'b1) begin n_err++; $display("FAIL b2b_res_c_en: got %b want 1", bus.en); end
        tick();
        drive(32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b10) begin n_err++; $display("FAIL b2b_spec: got %b want 10", bus.pattern_addr); end
        drive(32'h0, 1'b1, 2'b11, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b10) begin n_err++; $display("FAIL b2b_d_addr: got %b want 10", bus.pattern_addr); end
        tick();
        drive(32'h0, 1'b0, 2'b00, 1'b1, 1'b0);
        n_cmp++; if (bus.mispredict !== 1'b1) begin n_err++; $display("FAIL b2b_res_d_mp: got %b want 1", bus.mispredict); end
        tick();
        // arch_ghr was 10, resolved not-taken: restored spec_ghr = {0,0}.
        drive(32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b00) begin n_err++; $display("FAIL b2b_arch_restore: got %b want 00", bus.pattern_addr); end
    endtask

    task automatic test_async_reset();
        drive(32'h0, 1'b1, 2'b11, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b1, 2'b11, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        n_cmp++; if (bus.pattern_addr !== 2'b11) begin n_err++; $display("FAIL ar_spec_pre: got %b want 11", bus.pattern_addr); end
        drive(32'h8, 1'b1, 2'b11, 1'b1, 1'b1);
        #1;
        rstn = 1'b0;
        #1;
        n_cmp++; if (bus.en !== 1'b0) begin n_err++; $display("FAIL ar_en: got %b want 0", bus.en); end
        n_cmp++; if (bus.pcbranch !== 1'b0) begin n_err++; $display("FAIL ar_pcbranch: got %b want 0", bus.pcbranch); end
        n_cmp++; if (bus.mispredict !== 1'b0) begin n_err++; $display("FAIL ar_mispredict: got %b want 0", bus.mispredict); end
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL ar_stall: got %b want 1", bus.stall); end
        n_cmp++; if (bus.pattern_addr !== 2'b10) begin n_err++; $display("FAIL ar_addr: got %b want 10", bus.pattern_addr); end
        n_cmp++; if (bus.protocol_err !== 1'b0) begin n_err++; $display("FAIL ar_perr: got %b want 0", bus.protocol_err); end
        drive(32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        rstn = 1'b1;
        tick();
        drive(32'h0, 1'b1, 2'b11, 1'b0, 1'b0);
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL ar_not_full: got %b want 0", bus.stall); end
        n_cmp++; if (bus.pattern_addr !== 2'b00) begin n_err++; $display("FAIL ar_spec_clear: got %b want 00", bus.pattern_addr); end
        n_cmp++; if (bus.pred_taken !== 1'b1) begin n_err++; $display("FAIL ar_push_pred: got %b want 1", bus.pred_taken); end
        drive(32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b0;
        drive(32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_push();
        test_full();
        test_resolve();
        test_protocol_err();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
